// File: rtl/tlul_addr_steer_if.sv
// Bus bundle for the TL-UL address steering stage: the host-side request and
// response words plus the flattened per-device request and response words.
interface tlul_addr_steer_if #(
  parameter int N = 4
);
  logic [101:0]      tl_h_i;  // host h2d
  logic [67:0]       tl_h_o;  // host d2h
  logic [N*102-1:0]  tl_d_o;  // device h2d, device i at [102*i +: 102]
  logic [N*68-1:0]   tl_d_i;  // device d2h, device i at [68*i +: 68]

  // Environment side: issues host requests and returns device responses.
  modport master (
    output tl_h_i,
    output tl_d_i,
    input  tl_h_o,
    input  tl_d_o
  );

  // Steering stage side.
  modport slave (
    input  tl_h_i,
    input  tl_d_i,
    output tl_h_o,
    output tl_d_o
  );
endinterface

// File: rtl/tlul_addr_steer.sv
// 1:N TL-UL steering stage. Decodes the host A-channel address against
// per-device base/mask windows, forwards the request to the hit device (or to
// an internal error responder for unmapped addresses), counts outstanding
// transactions and returns D-channel responses strictly in order by never
// switching target while responses are still pending.

// Error responder for unmapped addresses: accepts one request at a time and
// answers it with d_error set and all-ones data.
module tlul_err_resp (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [101:0] tl_h_i,
  output logic [67:0]  tl_h_o
);
  typedef enum logic { ErrIdle, ErrRsp } err_state_e;

  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  err_state_e  state;
  logic [2:0]  rsp_opcode;
  logic [1:0]  rsp_size;
  logic [7:0]  rsp_source;
  logic        a_ready;
  logic        a_fire;
  logic        d_fire;
  logic        unused_h2d;

  assign a_ready = (state == ErrIdle);
  assign a_fire  = tl_h_i[101] & a_ready;
  assign d_fire  = (state == ErrRsp) & tl_h_i[0];

  // Only opcode, size and source shape the error response.
  assign unused_h2d = ^{tl_h_i[97:95], tl_h_i[84:1]};

  // Capture the request and hold the error response until the host takes it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= ErrIdle;
      rsp_opcode <= OpAccessAck;
      rsp_size   <= '0;
      rsp_source <= '0;
    end else begin
      case (state)
        ErrIdle: if (a_fire) begin
          state      <= ErrRsp;
          rsp_opcode <= (tl_h_i[100:98] == OpGet) ? OpAccessAckData : OpAccessAck;
          rsp_size   <= tl_h_i[94:93];
          rsp_source <= tl_h_i[92:85];
        end
        ErrRsp: if (d_fire) begin
          state <= ErrIdle;
        end
        default: state <= ErrIdle;
      endcase
    end
  end

  assign tl_h_o = {(state == ErrRsp), rsp_opcode, 3'd0, rsp_size, rsp_source,
                   1'b0, 32'hffff_ffff, 16'h0, 1'b1, a_ready};
endmodule

module tlul_addr_steer #(
  parameter int              N              = 4,
  parameter int              MaxOutstanding = 8,
  parameter logic [N*32-1:0] AddrBase       = {N{32'h0}},
  parameter logic [N*32-1:0] AddrMask       = {N{32'hffff_f000}}
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tlul_addr_steer_if.slave   tl
);
  localparam int IdxW = $clog2(N + 1);

  logic                  a_valid;
  logic                  d_ready;
  logic [31:0]           a_address;
  logic [IdxW-1:0]       dec_idx;
  logic [IdxW-1:0]       cur_tgt;
  logic [7:0]            out_cnt;
  logic                  pending;
  logic                  stall;
  logic                  h_a_ready;
  logic                  h_d_valid;
  logic                  a_fire;
  logic                  d_fire;
  logic [N:0][67:0]      tgt_d2h;   // index N is the error responder
  logic [101:0]          err_h2d;

  assign a_valid   = tl.tl_h_i[101];
  assign d_ready   = tl.tl_h_i[0];
  assign a_address = tl.tl_h_i[84:53];

  // Address decode: lowest-numbered hitting window wins, N when nothing hits.
  // NOTE: dec_idx gets its default before the loop so every path assigns it and no latch is inferred.
  always_comb begin
    dec_idx = IdxW'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if ((a_address & AddrMask[32*i +: 32]) == AddrBase[32*i +: 32]) begin
        dec_idx = IdxW'(i);
      end
    end
  end

  assign pending   = (out_cnt != 8'd0);
  assign stall     = (pending && (dec_idx != cur_tgt)) || (out_cnt == 8'(MaxOutstanding));
  assign h_a_ready = ~stall & tgt_d2h[dec_idx][0];
  assign a_fire    = a_valid & h_a_ready;
  // A response arriving with nothing outstanding is not ours to forward.
  assign h_d_valid = pending & tgt_d2h[cur_tgt][67];
  assign d_fire    = h_d_valid & d_ready;

  assign tl.tl_h_o = {h_d_valid, tgt_d2h[cur_tgt][66:1], h_a_ready};

  // Per-device request fan-out and response collection.
  for (genvar g = 0; g < N; g++) begin : g_dev
    assign tl.tl_d_o[102*g +: 102] = {a_valid & ~stall & (dec_idx == IdxW'(g)),
                                      tl.tl_h_i[100:1],
                                      pending & d_ready & (cur_tgt == IdxW'(g))};
    assign tgt_d2h[g] = tl.tl_d_i[68*g +: 68];
  end

  assign err_h2d = {a_valid & ~stall & (dec_idx == IdxW'(N)),
                    tl.tl_h_i[100:1],
                    pending & d_ready & (cur_tgt == IdxW'(N))};

  tlul_err_resp u_err_resp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tl_h_i (err_h2d),
    .tl_h_o (tgt_d2h[N])
  );

  // Outstanding-transaction counter and current target tracking.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_cnt <= 8'd0;
      cur_tgt <= '0;
    end else begin
      if (a_fire) begin
        cur_tgt <= dec_idx;
      end
      if (a_fire && !d_fire) begin
        out_cnt <= out_cnt + 8'd1;
      end else if (!a_fire && d_fire) begin
        out_cnt <= out_cnt - 8'd1;
      end
    end
  end
endmodule
